// File: rtl/pd_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : pd_window_counter
// Purpose  : Counts rising edges of the sequence-detector output `pd` over
//            fixed windows of WIN_LEN cycles and publishes each window's count
//            through a valid/ready output register. Raises a one-cycle alarm
//            when a window count reaches THRESH, keeps a wrapping 16-bit total
//            of counted events, and flags results dropped while the sink stalls.
// Ports    : clk        - clock, all state updates on rising edge
//            rst        - asynchronous active-low reset
//            pd         - detector level; one event per 0->1 transition
//            en         - counting enable (IDLE <-> RUN)
//            win_ready  - sink accepts the result
//            ovr_clr    - synchronous clear of overrun
//            win_valid  - win_cnt holds an unconsumed result
//            win_cnt    - count of the completed window (saturating)
//            alarm      - one-cycle pulse after a close with result >= THRESH
//            overrun    - sticky, set when a result is dropped
//            total_cnt  - wrapping count of all events counted in RUN
// Revision : 1.0 - initial release
// ============================================================================
module pd_window_counter #(
    parameter int WIN_LEN = 32,
    parameter int CNT_W   = 6,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pd,
    input  logic             en,
    input  logic             win_ready,
    input  logic             ovr_clr,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_cnt,
    output logic             alarm,
    output logic             overrun,
    output logic [15:0]      total_cnt
);

    localparam int               c_TW      = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [c_TW-1:0]  c_LAST    = c_TW'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [31:0]      c_THRESH  = THRESH;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_pd_q;
    logic [c_TW-1:0]  r_timer;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_win_valid;
    logic [CNT_W-1:0] r_win_cnt;
    logic             r_alarm;
    logic             r_overrun;
    logic [15:0]      r_total;

    logic             w_edge;
    logic             w_run_step;
    logic             w_close;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_result;
    logic             w_hs;
    logic             w_load;
    logic             w_drop;
    logic             w_over_thr;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (en)  w_state_nxt = c_RUN;
            c_RUN:   if (!en) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    assign w_edge     = pd & ~r_pd_q;
    // Only a RUN cycle that stays in RUN advances the window; dropping en
    // aborts the partial window, so its closing edge never counts.
    assign w_run_step = (r_state == c_RUN) & en;
    assign w_close    = w_run_step & (r_timer == c_LAST);
    assign w_cnt_inc  = (r_wcnt == c_CNT_MAX) ? c_CNT_MAX : (r_wcnt + CNT_W'(1));
    // The edge on the closing cycle belongs to the closing window.
    assign w_result   = w_edge ? w_cnt_inc : r_wcnt;
    assign w_over_thr = (32'(w_result) >= c_THRESH);

    assign w_hs       = r_win_valid & win_ready;
    // A full register can still accept when it is being drained this cycle.
    assign w_load     = w_close & (~r_win_valid | win_ready);
    assign w_drop     = w_close & r_win_valid & ~win_ready;

    // ------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pd_q      <= 1'b0;
            r_timer     <= '0;
            r_wcnt      <= '0;
            r_win_valid <= 1'b0;
            r_win_cnt   <= '0;
            r_alarm     <= 1'b0;
            r_overrun   <= 1'b0;
            r_total     <= '0;
        end else begin
            r_pd_q <= pd;

            if (!w_run_step || w_close) begin
                r_timer <= '0;
                r_wcnt  <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
                if (w_edge) begin
                    r_wcnt <= w_cnt_inc;
                end
            end

            if (w_run_step && w_edge) begin
                r_total <= r_total + 16'd1;
            end

            if (w_load) begin
                r_win_valid <= 1'b1;
                r_win_cnt   <= w_result;
            end else if (w_hs) begin
                r_win_valid <= 1'b0;
            end

            // Alarm reflects the window result even when it is dropped.
            r_alarm <= w_close & w_over_thr;

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign win_valid = r_win_valid;
    assign win_cnt   = r_win_cnt;
    assign alarm     = r_alarm;
    assign overrun   = r_overrun;
    assign total_cnt = r_total;

endmodule
`default_nettype wire

// File: doc/pd_window_counter.md
# pd_window_counter

Downstream consumer of the sequence detector's `pd` output. It counts detection events (rising edges of `pd`) over fixed windows of `WIN_LEN` clock cycles and publishes each window's count through a valid/ready output register. It also raises a one-cycle alarm when a window's count reaches `THRESH`, keeps a running 16-bit total, and flags windows dropped because the sink was not ready.

## Interface
Parameters:
- `WIN_LEN`, default 32: window length in clock cycles; must be ≥ 2.
- `CNT_W`, default 6: width of the per-window count, which saturates.
- `THRESH`, default 3: alarm threshold; alarm fires when the window count is ≥ `THRESH`.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-low reset; `rst`=0 clears all state immediately.
- `pd`  in  1  — detector output (level); one event is counted per 0→1 transition.
- `en`  in  1  — counting enable.
- `win_ready`  in  1  — sink accepts the result.
- `ovr_clr`  in  1  — synchronous clear of `overrun`.
- `win_valid`  out  1  — `win_cnt` holds an unconsumed result.
- `win_cnt`  out  `CNT_W`  — count for the completed window.
- `alarm`  out  1  — one-cycle pulse on a window close whose result is ≥ `THRESH`.
- `overrun`  out  1  — sticky; set when a result is dropped.
- `total_cnt`  out  16  — wrapping count of all events counted while in RUN.

## Operation
- **Edge detect:** `pd_q` registers `pd` every cycle in both states. An event is `edge = pd & ~pd_q`.
- **States:** IDLE and RUN.
  - IDLE → RUN on any posedge with `en`=1. The timer is 0 for the first RUN cycle.
  - RUN → IDLE on any posedge with `en`=0. The timer and window count clear, and the partial window is discarded: no result, no alarm.
  - Edges occurring while in IDLE are not counted.
- **In RUN, each posedge:**
  - If `edge`, the window count increments (saturating at 2^`CNT_W`−1) and `total_cnt` increments (wrapping at 2^16).
  - If the timer < `WIN_LEN`−1, the timer increments.
  - If the timer = `WIN_LEN`−1, the window closes:
    - result = saturating(window count + `edge`);
    - the timer and window count reset to 0;
    - the result is offered to the output register.
- **Output register** (updated in IDLE as well as RUN):
  - A handshake completes at a posedge with `win_valid`=1 and `win_ready`=1.
  - Window close, register empty or handshake completing the same cycle: load the result; `win_valid`=1.
  - Window close, register full and no handshake: keep the old result, drop the new one, set `overrun`=1.
  - Handshake with no close: `win_valid`→0. `win_cnt` holds its stale value.
- **Alarm:** `alarm`=1 for exactly the cycle after any window close whose result is ≥ `THRESH`, including a dropped result.
- **Overrun clear:** `ovr_clr`=1 clears `overrun` at the posedge. A same-cycle set wins over the clear.
- **Reset (`rst`=0):** `win_valid`, `win_cnt`, `alarm`, `overrun`, `total_cnt`, `pd_q`, the timer and the window count all go to 0, and the state goes to IDLE, asynchronously. Release is synchronous to the next posedge.

## Timing
- An event is counted at the posedge where `pd`=1 and `pd_q`=0, i.e. the first rising edge of `clk` that samples `pd` high.
- A window spans `WIN_LEN` posedges in RUN. `win_valid` and `alarm` are high in the cycle following the closing posedge.
- Close-to-output latency is 1 cycle. A result can be consumed in the same cycle it becomes valid.
- Back-to-back windows with `win_ready` held at 1 produce one `win_valid` cycle per window, with no bubbles lost.
- `total_cnt` is visible 1 cycle after the counting posedge.
- Simultaneous close, edge and handshake: the edge is included in the closing result, the new result loads, and `win_valid` stays 1.

## Test plan
- **Mid-run reset:** run with a count of 2, then pulse `rst`=0 for 3 ns between clock edges → all outputs 0 immediately with no clock edge. After release with `en`=1, the window restarts with timer 0.
- **Basic window:** `en`=1, `win_ready`=1, three 1-cycle `pd` pulses at RUN cycles 4, 10, 31 → `win_valid`=1 for one cycle after the 32nd posedge with `win_cnt`=3, `alarm` pulses once, `total_cnt`=3. The cycle-31 edge lands in window 0.
- **Held level:** `pd` held high for 10 cycles inside one window → `win_cnt`=1, `alarm` stays 0.
- **Dropped window:** `win_ready`=0 across two windows with counts 2 and 4 → `win_cnt` stays 2, `overrun`=1, `alarm` pulses for the second window only. Then `ovr_clr`=1 → `overrun`=0. Then `win_ready`=1 → `win_valid` drops.
- **Saturation:** with `WIN_LEN`=200, `pd` toggling every cycle (100 edges) → `win_cnt`=63 and `total_cnt`=100.
- **Enable abort:** drop `en` after 2 edges at timer 20 → no `win_valid` and no `alarm`. Re-raise `en` → the next full window reports only the new edges.
